pattern_sequencer: RTL

- Parametrised pattern bank plus step sequencer; successor to the fixed 4 x 16-bit note pattern store.
- Holds NUM_CH patterns of STEPS bits each, loaded one channel at a time, like the existing store.
- Adds a tempo-driven step counter that plays every channel's current step bit in parallel.
- Sits between the switch/key input logic and the per-channel speaker drivers.

---
 rtl/seq_pkg.sv | 12 +
 rtl/pattern_sequencer_tempo_divider.sv | 36 +++
 rtl/pattern_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared defaults, FSM state type and board clock rate for the pattern sequencer.
package seq_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int STEPS_DEF  = 16;
  localparam int DIV_W_DEF  = 26;
  localparam int CLK_HZ     = 50_000_000;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } seq_state_t;
endpackage

// File: rtl/pattern_sequencer_tempo_divider.sv
// Step-rate divider: counts clk cycles while enabled and fires every max(tempo_div,1) cycles.
// adv is combinational for same-edge step advance; step_tick is its registered one-cycle pulse.
module tempo_divider #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] tempo_div,
  output logic             adv,
  output logic             step_tick
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] term;

  // >= rather than == so a shortened tempo ends an overrun step on the next cycle.
  always_comb begin
    term = (tempo_div == '0) ? '0 : tempo_div - DIV_W'(1);
    adv  = en && !restart && (cnt >= term);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= adv;
      if (restart || adv) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end
endmodule

// File: rtl/pattern_sequencer.sv
// NUM_CH x STEPS pattern bank with tempo-driven step playback; notes lag step_idx/patterns by 1 cycle.
// Loads land 3 edges after a load rise; SEQ_MUTE_EN adds a per-channel mute input on notes.
module pattern_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int STEPS  = STEPS_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [STEPS-1:0]           pattern,
  input  logic [$clog2(NUM_CH)-1:0]  sel,
  input  logic                       load,
  input  logic                       run,
  input  logic                       restart,
  input  logic [DIV_W-1:0]           tempo_div,
`ifdef SEQ_MUTE_EN
  input  logic [NUM_CH-1:0]          mute,
`endif
  output logic [NUM_CH-1:0]          notes,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       step_tick,
  output logic                       busy
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int IDX_W = $clog2(STEPS);

  logic             load_s1, load_s2, load_s3;
  logic             load_rise;
  logic [STEPS-1:0] pat [NUM_CH];
  seq_state_t       state, state_d;
  logic             step_en;
  logic             adv;

  // load is an asynchronous key level: synchronise, then act on its rising edge only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_s1 <= 1'b0;
      load_s2 <= 1'b0;
      load_s3 <= 1'b0;
    end else begin
      load_s1 <= load;
      load_s2 <= load_s1;
      load_s3 <= load_s2;
    end
  end

  assign load_rise = load_s2 & ~load_s3;

  // An out-of-range sel matches no channel, so nothing is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pat[c] <= '0;
      end
    end else if (load_rise) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel == SEL_W'(c)) begin
          pat[c] <= pattern;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STOP;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      STOP:    if (run)  state_d = RUN;
      RUN:     if (!run) state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  always_comb begin
    step_en = (state == RUN);
  end

  tempo_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .en        (step_en),
    .restart   (restart),
    .tempo_div (tempo_div),
    .adv       (adv),
    .step_tick (step_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_idx <= '0;
    end else if (restart) begin
      step_idx <= '0;
    end else if (adv) begin
      step_idx <= (step_idx == IDX_W'(STEPS - 1)) ? '0 : step_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      notes <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef SEQ_MUTE_EN
        notes[c] <= pat[c][step_idx] & ~mute[c];
`else
        notes[c] <= pat[c][step_idx];
`endif
      end
    end
  end
endmodule
